mantissa_normalizer: RTL

//   Multi-cycle left-normalizer for FP mantissa/exponent pairs. Inverse-side partner of the

---
 rtl/mantissa_normalizer_if.sv | 29 ++
 rtl/mantissa_normalizer.sv | 97 +++++++++
 2 files changed

// File: rtl/mantissa_normalizer_if.sv
// Handshake bundle between the FP add/sub result stage, the normalizer and the round/pack stage.
// The slave side is the normalizer; the master side is its environment.
interface mantissa_normalizer_if #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic [CNT_W-1:0]  out_shift;
  logic              out_zero;
  logic              out_denorm;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_denorm
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_denorm
  );
endinterface

// File: rtl/mantissa_normalizer.sv
// Multi-cycle left-normalizer: shifts the mantissa one bit per cycle until the hidden-one
// position is set or the exponent bottoms out, reporting the applied shift count.
module mantissa_normalizer #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mantissa_normalizer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  shift_q, shift_d;
  logic              zero_q, zero_d;
  logic              denorm_q, denorm_d;

  // State and datapath registers; reset discards any operand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    shift_d  = shift_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shift_d  = '0;
          zero_d   = 1'b0;
          denorm_d = 1'b0;
          if (bus.in_mant == '0) begin
            // A zero mantissa never finds a leading one: report a full-width shift.
            mant_d  = '0;
            exp_d   = '0;
            shift_d = CNT_W'(MANT_W);
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            mant_d  = bus.in_mant;
            exp_d   = bus.in_exp;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (mant_q[MANT_W-1]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          denorm_d = 1'b1;
          state_d  = DONE;
        end else begin
          mant_d  = {mant_q[MANT_W-2:0], 1'b0};
          exp_d   = exp_q - EXP_W'(1);
          shift_d = shift_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_mant   = mant_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_shift  = shift_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_denorm = denorm_q;

endmodule
